uart_rx: RTL and testbench
==========================

# uart_rx

Parameterised UART receiver, the receive-side counterpart of the team's `uart_tx`. It recovers 8N1 frames (start bit, LSB-first data, one stop bit) from an asynchronous serial line, using a per-bit clock counter and mid-bit sampling. It presents each received byte with a one-cycle valid strobe and flags framing errors. It sits between the board RX pin and the byte-level consumer logic in the ParamUART subsystem.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 4 and even.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5–8.
- `clk`  input  1: single system clock; all logic is on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `rx`  input  1: serial line, idle high, asynchronous to `clk`.
- `data`  output  DATA_BITS: last correctly received byte; holds its value until the next good frame.
- `valid`  output  1: one-cycle pulse when `data` is updated.
- `frame_err`  output  1: one-cycle pulse when a stop bit is sampled low.
- `busy`  output  1: high in every state except IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser to produce `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **States:** IDLE, START, DATA, STOP, BREAK. The bit counter is `$clog2(DATA_BITS)+1` bits wide. The clock counter is `$clog2(CLKS_PER_BIT)` bits wide.
- **IDLE:** when `rx_s==0`, clear the clock counter and go to START.
- **START:** count to `CLKS_PER_BIT/2-1` (the mid-point of the start bit).
  - If `rx_s==0` at that point: clear both counters and go to DATA.
  - Otherwise: false start; return to IDLE with no output activity.
- **DATA:** count to `CLKS_PER_BIT-1`, then sample `rx_s` and clear the clock counter.
  - Each sample shifts right into the shift register, with the new bit entering at MSB, so the first-received bit ends at bit 0.
  - After `DATA_BITS` samples, go to STOP.
- **STOP:** count to `CLKS_PER_BIT-1`, then sample `rx_s`.
  - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s==1`, then go to IDLE. This prevents a held-low line from being taken as repeated start bits.
- `valid` and `frame_err` are never high in the same cycle, and neither is ever high for more than one cycle.
- Counters never wrap inside a bit: each counter is cleared on reaching its terminal count.
- **Reset (at any time, including mid-frame):**
  - state = IDLE, all counters = 0, shift register = 0.
  - `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - Synchroniser flops = 1.

## Timing
- Synchroniser latency is 2 cycles from an `rx` edge to the matching `rx_s` edge.
- Start-bit qualification happens `CLKS_PER_BIT/2` cycles after IDLE sees `rx_s` low.
- Data bit n (0-based) is sampled `CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT` cycles after start detection.
- `valid` / `frame_err` is registered and asserts on the edge that samples the stop bit. That is `2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT` cycles after the `rx` falling edge of the start bit. The bench tolerance is ±2 cycles.
- `busy` rises the cycle after IDLE detects `rx_s` low. It falls in the cycle `valid` pulses, or the cycle BREAK exits.
- **Back-to-back frames:** STOP returns to IDLE half a bit before the nominal stop-bit end. A start bit immediately following a stop bit is therefore always caught.
- **Baud tolerance:** cumulative sender/receiver clock mismatch must stay below ±(CLKS_PER_BIT/2 − 1) cycles over a frame. Outside that limit, behaviour is undefined but must never deadlock: BREAK and IDLE are always reachable.
- No back-pressure: the consumer must take `data` within one frame time. `data` remains stable until the next `valid`.

## Test plan
- **Single frame:** `CLKS_PER_BIT=16`, drive 0xA5 as 8N1 → exactly one `valid` pulse at cycle ≈ 2+8+144 after the start edge, `data==0xA5`, `frame_err` never high, `busy` high during the frame.
- **Back-to-back frames:** 0x00, 0xFF, 0x3C with zero idle gap → three `valid` pulses spaced 160 cycles apart, with `data` = 0x00, 0xFF, 0x3C in order.
- **Glitch rejection:** low pulse of 4 cycles on an idle line → no `valid`, no `frame_err`, `busy` returns to 0 within 12 cycles; a following 0x55 frame is received correctly.
- **Framing error:** good 0x12 frame, then 0x34 with its stop bit low and the line held low 50 cycles → `frame_err` pulses once, `data` stays 0x12, no `valid`; after the line returns high, a 0x56 frame gives `valid` with `data==0x56`.
- **Reset mid-frame:** assert `rst` low during data bit 4 of 0x99 → all outputs go to 0 immediately (asynchronously); release reset and send 0xC3 → `valid` with `data==0xC3`.
- **Parameter variation:** `CLKS_PER_BIT=4`, `DATA_BITS=7`, send 0x5A → `valid` with `data==0x5A`, latency within ±2 cycles of the formula.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: recovers start / LSB-first data / stop frames from an asynchronous
// serial line using a per-bit clock counter and mid-bit sampling.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 sync1_q, sync2_q;
    logic                 rx_s;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                // Leaving mid-stop-bit gives half a bit of slack for the next start edge.
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 16x/8-bit instance plus a 4x/7-bit instance.
module tb_uart_rx;
    logic       clk;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic       valid_a, frame_err_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, frame_err_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         va_cyc[$];
    logic [7:0] va_dat[$];
    int         fe_a = 0;
    int         dbl_a = 0;
    logic       prev_pulse_a = 1'b0;
    int         vb_cyc[$];
    logic [6:0] vb_dat[$];
    int         fe_b = 0;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .data(data_a), .valid(valid_a), .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(7)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .data(data_b), .valid(valid_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid_a) begin
            va_cyc.push_back(cyc);
            va_dat.push_back(data_a);
        end
        if (frame_err_a) fe_a = fe_a + 1;
        if ((valid_a && frame_err_a) || (prev_pulse_a && (valid_a || frame_err_a)))
            dbl_a = dbl_a + 1;
        prev_pulse_a = valid_a | frame_err_a;
        if (valid_b) begin
            vb_cyc.push_back(cyc);
            vb_dat.push_back(data_b);
        end
        if (frame_err_b) fe_b = fe_b + 1;
    end

    task automatic send_a(input logic [7:0] b, input logic stop_bit);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            repeat (16) @(negedge clk);
        end
        rx_a = stop_bit;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
    endtask

    task automatic clear_a();
        va_cyc.delete();
        va_dat.delete();
        fe_a = 0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_a); end
        n_checks++; if (frame_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int t0;
        int lat;
        logic busy_seen;
        clear_a();
        t0 = cyc;
        busy_seen = 1'b0;
        fork
            send_a(8'hA5, 1'b1);
            repeat (100) begin @(negedge clk); if (busy_a) busy_seen = 1'b1; end
        join
        repeat (40) @(negedge clk);
        n_checks++; if (va_cyc.size() != 1) begin n_fail++; $display("FAIL single_valid_count got %0d want 1", va_cyc.size()); end
        if (va_cyc.size() >= 1) begin
            lat = va_cyc[0] - t0;
            n_checks++; if (va_dat[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", va_dat[0]); end
            n_checks++; if (lat < 152 || lat > 156) begin n_fail++; $display("FAIL single_latency got %0d want 154+-2", lat); end
        end
        n_checks++; if (fe_a != 0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", fe_a); end
        n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy_seen); end
        $display("test_single_frame: 0xA5 -> %0d valid pulse(s)", va_cyc.size());
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
        clear_a();
        for (int k = 0; k < 3; k++) send_a(exp[k], 1'b1);
        repeat (40) @(negedge clk);
        n_checks++; if (va_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_valid_count got %0d want 3", va_cyc.size()); end
        if (va_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (va_dat[k] !== exp[k]) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", k, va_dat[k], exp[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (va_cyc[k] - va_cyc[k-1] != 160) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 160", k, va_cyc[k] - va_cyc[k-1]); end
            end
        end
        n_checks++; if (dbl_a != 0) begin n_fail++; $display("FAIL pulse_overlap got %0d want 0", dbl_a); end
        $display("test_back_to_back: 00/FF/3C -> %0d valid pulse(s)", va_cyc.size());
    endtask

    task automatic test_glitch();
        clear_a();
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy_a); end
        n_checks++; if (va_cyc.size() != 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", va_cyc.size()); end
        n_checks++; if (fe_a != 0) begin n_fail++; $display("FAIL glitch_frame_err got %0d want 0", fe_a); end
        send_a(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++; if (va_cyc.size() != 1 || data_a !== 8'h55) begin n_fail++; $display("FAIL glitch_next_frame got %0d pulses data %h want 1 pulse data 55", va_cyc.size(), data_a); end
        $display("test_glitch: 4-cycle low pulse then 0x55");
    endtask

    task automatic test_framing_error();
        clear_a();
        send_a(8'h12, 1'b1);
        send_a(8'h34, 1'b0);
        rx_a = 1'b0;
        repeat (50) @(negedge clk);
        rx_a = 1'b1;
        repeat (32) @(negedge clk);
        n_checks++; if (fe_a != 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", fe_a); end
        n_checks++; if (va_cyc.size() != 1) begin n_fail++; $display("FAIL ferr_valid_count got %0d want 1", va_cyc.size()); end
        n_checks++; if (data_a !== 8'h12) begin n_fail++; $display("FAIL ferr_data_hold got %h want 12", data_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit got busy %b want 0", busy_a); end
        send_a(8'h56, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++; if (va_cyc.size() != 2 || data_a !== 8'h56) begin n_fail++; $display("FAIL ferr_recover got %0d pulses data %h want 2 pulses data 56", va_cyc.size(), data_a); end
        $display("test_framing_error: 0x12 good, 0x34 bad stop, 0x56 good");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h99;
        clear_a();
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = b[i];
            repeat (16) @(negedge clk);
        end
        rx_a = b[4];
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", data_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        n_checks++; if (valid_a !== 1'b0 || frame_err_a !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses got %b%b want 00", valid_a, frame_err_a); end
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_a(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++; if (va_cyc.size() != 1 || data_a !== 8'hC3) begin n_fail++; $display("FAIL midrst_recover got %0d pulses data %h want 1 pulse data c3", va_cyc.size(), data_a); end
        n_checks++; if (fe_a != 0) begin n_fail++; $display("FAIL midrst_frame_err got %0d want 0", fe_a); end
        $display("test_reset_mid_frame: reset during 0x99, then 0xC3");
    endtask

    task automatic test_param_variation();
        logic [6:0] b;
        int t0;
        int lat;
        b = 7'h5A;
        vb_cyc.delete();
        vb_dat.delete();
        fe_b = 0;
        t0 = cyc;
        rx_b = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx_b = b[i];
            repeat (4) @(negedge clk);
        end
        rx_b = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (vb_cyc.size() != 1) begin n_fail++; $display("FAIL param_valid_count got %0d want 1", vb_cyc.size()); end
        if (vb_cyc.size() >= 1) begin
            lat = vb_cyc[0] - t0;
            n_checks++; if (vb_dat[0] !== 7'h5A) begin n_fail++; $display("FAIL param_data got %h want 5a", vb_dat[0]); end
            n_checks++; if (lat < 34 || lat > 38) begin n_fail++; $display("FAIL param_latency got %0d want 36+-2", lat); end
        end
        n_checks++; if (fe_b != 0) begin n_fail++; $display("FAIL param_frame_err got %0d want 0", fe_b); end
        $display("test_param_variation: 7-bit 0x5A at 4 clocks/bit");
    endtask

    initial begin
        rst  = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_param_variation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
